// File: rtl/reg_file_port_master.sv
// Command-driven initiator for the register file: LOAD streams bytes into consecutive
// registers, DUMP reads register pairs through both read ports and streams them out.
module reg_file_port_master #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int READ_WAIT  = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic                  CMD_OP,
    input  logic [ADDR_WIDTH-1:0] CMD_BASE,
    input  logic [ADDR_WIDTH:0]   CMD_COUNT,
    input  logic                  S_VALID,
    output logic                  S_READY,
    input  logic [DATA_WIDTH-1:0] S_DATA,
    output logic                  M_VALID,
    input  logic                  M_READY,
    output logic [DATA_WIDTH-1:0] M_DATA,
    output logic [DATA_WIDTH-1:0] RF_IN,
    output logic [ADDR_WIDTH-1:0] RF_INADDRESS,
    output logic                  RF_WRITE,
    output logic [ADDR_WIDTH-1:0] RF_OUT1ADDRESS,
    output logic [ADDR_WIDTH-1:0] RF_OUT2ADDRESS,
    input  logic [DATA_WIDTH-1:0] RF_OUT1,
    input  logic [DATA_WIDTH-1:0] RF_OUT2,
    output logic                  BUSY,
    output logic                  DONE
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] NUM_REGS_CNT = (ADDR_WIDTH + 1)'(NUM_REGS);
    localparam int WAIT_W = $clog2(READ_WAIT + 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LOAD_LAST,
        ST_DUMP_ADDR,
        ST_DUMP_WAIT,
        ST_DUMP_LO,
        ST_DUMP_HI,
        ST_FINISH
    } state_t;

    state_t                 state_reg, state_next;
    logic [ADDR_WIDTH-1:0]  idx_reg, idx_next;
    logic [ADDR_WIDTH:0]    rem_reg, rem_next;
    logic [WAIT_W-1:0]      wait_reg, wait_next;
    logic [DATA_WIDTH-1:0]  lo_reg, lo_next;
    logic [DATA_WIDTH-1:0]  hi_reg, hi_next;
    logic [DATA_WIDTH-1:0]  rf_in_reg, rf_in_next;
    logic [ADDR_WIDTH-1:0]  rf_inaddr_reg, rf_inaddr_next;
    logic                   rf_write_reg, rf_write_next;
    logic [ADDR_WIDTH:0]    count_clamped;
    logic                   dump_rd;

    assign count_clamped = (CMD_COUNT > NUM_REGS_CNT) ? NUM_REGS_CNT : CMD_COUNT;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            rem_reg       <= '0;
            wait_reg      <= '0;
            lo_reg        <= '0;
            hi_reg        <= '0;
            rf_in_reg     <= '0;
            rf_inaddr_reg <= '0;
            rf_write_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            rem_reg       <= rem_next;
            wait_reg      <= wait_next;
            lo_reg        <= lo_next;
            hi_reg        <= hi_next;
            rf_in_reg     <= rf_in_next;
            rf_inaddr_reg <= rf_inaddr_next;
            rf_write_reg  <= rf_write_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        rem_next       = rem_reg;
        wait_next      = wait_reg;
        lo_next        = lo_reg;
        hi_next        = hi_reg;
        rf_in_next     = rf_in_reg;
        rf_inaddr_next = rf_inaddr_reg;
        rf_write_next  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (CMD_VALID) begin
                    idx_next = CMD_BASE;
                    rem_next = count_clamped;
                    if (count_clamped == '0)
                        state_next = ST_FINISH;
                    else if (!CMD_OP)
                        state_next = ST_LOAD;
                    else
                        state_next = ST_DUMP_ADDR;
                end
            end
            ST_LOAD: begin
                // The write is registered, so it lands one cycle after the beat.
                if (S_VALID) begin
                    rf_write_next  = 1'b1;
                    rf_in_next     = S_DATA;
                    rf_inaddr_next = idx_reg;
                    idx_next       = idx_reg + 1'b1;
                    rem_next       = rem_reg - 1'b1;
                    if (rem_reg == (ADDR_WIDTH + 1)'(1))
                        state_next = ST_LOAD_LAST;
                end
            end
            ST_LOAD_LAST: state_next = ST_FINISH;
            ST_DUMP_ADDR: begin
                wait_next  = '0;
                state_next = ST_DUMP_WAIT;
            end
            ST_DUMP_WAIT: begin
                if (int'(wait_reg) + 1 >= READ_WAIT) begin
                    lo_next    = RF_OUT1;
                    hi_next    = RF_OUT2;
                    state_next = ST_DUMP_LO;
                end else begin
                    wait_next = wait_reg + WAIT_W'(1);
                end
            end
            ST_DUMP_LO: begin
                if (M_READY) begin
                    rem_next   = rem_reg - 1'b1;
                    state_next = (rem_reg == (ADDR_WIDTH + 1)'(1)) ? ST_FINISH : ST_DUMP_HI;
                end
            end
            ST_DUMP_HI: begin
                if (M_READY) begin
                    rem_next   = rem_reg - 1'b1;
                    idx_next   = idx_reg + ADDR_WIDTH'(2);
                    state_next = (rem_reg == (ADDR_WIDTH + 1)'(1)) ? ST_FINISH : ST_DUMP_ADDR;
                end
            end
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Read addresses only leave zero while a pair is being fetched; idx is frozen there.
    assign dump_rd        = (state_reg == ST_DUMP_ADDR) || (state_reg == ST_DUMP_WAIT);
    assign RF_OUT1ADDRESS = dump_rd ? idx_reg : '0;
    assign RF_OUT2ADDRESS = dump_rd ? (idx_reg + 1'b1) : '0;

    assign CMD_READY    = (state_reg == ST_IDLE);
    assign BUSY         = (state_reg != ST_IDLE);
    assign DONE         = (state_reg == ST_FINISH);
    assign S_READY      = (state_reg == ST_LOAD);
    assign M_VALID      = (state_reg == ST_DUMP_LO) || (state_reg == ST_DUMP_HI);
    assign M_DATA       = (state_reg == ST_DUMP_LO) ? lo_reg :
                          (state_reg == ST_DUMP_HI) ? hi_reg : '0;
    assign RF_IN        = rf_in_reg;
    assign RF_INADDRESS = rf_inaddr_reg;
    assign RF_WRITE     = rf_write_reg;

endmodule

// File: tb/tb_reg_file_port_master.sv
// Directed bench for reg_file_port_master with a behavioural 8x8 register file
// (clocked write, asynchronous read) attached to its register-file ports.
module tb_reg_file_port_master;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       CMD_VALID = 1'b0;
    logic       CMD_READY;
    logic       CMD_OP = 1'b0;
    logic [2:0] CMD_BASE = '0;
    logic [3:0] CMD_COUNT = '0;
    logic       S_VALID = 1'b0;
    logic       S_READY;
    logic [7:0] S_DATA = '0;
    logic       M_VALID;
    logic       M_READY = 1'b0;
    logic [7:0] M_DATA;
    logic [7:0] RF_IN;
    logic [2:0] RF_INADDRESS;
    logic       RF_WRITE;
    logic [2:0] RF_OUT1ADDRESS, RF_OUT2ADDRESS;
    logic [7:0] RF_OUT1, RF_OUT2;
    logic       BUSY, DONE;

    int total = 0;
    int bad = 0;

    logic [7:0] rf_mem [8];
    logic [7:0] bytes_b [8];
    logic [7:0] exp_b [8];

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (RF_WRITE) rf_mem[RF_INADDRESS] <= RF_IN;
    assign RF_OUT1 = rf_mem[RF_OUT1ADDRESS];
    assign RF_OUT2 = rf_mem[RF_OUT2ADDRESS];

    reg_file_port_master #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .READ_WAIT(1)) dut (
        .CLK(CLK), .RESET(RESET),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
        .CMD_BASE(CMD_BASE), .CMD_COUNT(CMD_COUNT),
        .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA),
        .M_VALID(M_VALID), .M_READY(M_READY), .M_DATA(M_DATA),
        .RF_IN(RF_IN), .RF_INADDRESS(RF_INADDRESS), .RF_WRITE(RF_WRITE),
        .RF_OUT1ADDRESS(RF_OUT1ADDRESS), .RF_OUT2ADDRESS(RF_OUT2ADDRESS),
        .RF_OUT1(RF_OUT1), .RF_OUT2(RF_OUT2),
        .BUSY(BUSY), .DONE(DONE)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // LOAD with S_VALID held high; abort_at>0 pulses RESET after that many beats.
    task automatic do_load(input logic [2:0] base, input logic [3:0] cnt, input int abort_at);
        logic [2:0] ea;
        CMD_VALID = 1'b1; CMD_OP = 1'b0; CMD_BASE = base; CMD_COUNT = cnt;
        step();
        CMD_VALID = 1'b0;
        chk("load_s_ready", 32'(S_READY), 32'd1);
        chk("load_busy", 32'(BUSY), 32'd1);
        chk("load_cmd_ready", 32'(CMD_READY), 32'd0);
        S_VALID = 1'b1;
        for (int i = 0; i < int'(cnt); i++) begin
            S_DATA = bytes_b[i];
            step();
            ea = base + 3'(i);
            chk("load_rf_write", 32'(RF_WRITE), 32'd1);
            chk("load_rf_addr", 32'(RF_INADDRESS), 32'(ea));
            chk("load_rf_in", 32'(RF_IN), 32'(bytes_b[i]));
            if (abort_at == i + 1) begin
                RESET = 1'b0;
                S_VALID = 1'b0;
                #1;
                chk("abort_rf_write", 32'(RF_WRITE), 32'd0);
                chk("abort_busy", 32'(BUSY), 32'd0);
                chk("abort_cmd_ready", 32'(CMD_READY), 32'd1);
                chk("abort_s_ready", 32'(S_READY), 32'd0);
                step();
                chk("abort_done", 32'(DONE), 32'd0);
                chk("abort_rf_write2", 32'(RF_WRITE), 32'd0);
                RESET = 1'b1;
                step();
                chk("abort_done_after", 32'(DONE), 32'd0);
                $display("load base=%0d count=%0d aborted after %0d beats", base, cnt, abort_at);
                return;
            end
        end
        chk("load_last_s_ready", 32'(S_READY), 32'd0);
        S_VALID = 1'b0;
        step();
        chk("load_done", 32'(DONE), 32'd1);
        chk("load_finish_rf_write", 32'(RF_WRITE), 32'd0);
        step();
        chk("load_done_pulse", 32'(DONE), 32'd0);
        chk("load_cmd_ready_back", 32'(CMD_READY), 32'd1);
        $display("load base=%0d count=%0d complete", base, cnt);
    endtask

    // DUMP collecting beats; compares against exp_b and checks hold/DONE timing.
    task automatic do_dump(input logic [2:0] base, input logic [3:0] cnt, input bit toggle,
                           input int nexp, input int exp_a2);
        int n, last_beat, done_cyc, wr, a2;
        bit stall;
        logic [7:0] held;
        CMD_VALID = 1'b1; CMD_OP = 1'b1; CMD_BASE = base; CMD_COUNT = cnt;
        step();
        CMD_VALID = 1'b0;
        n = 0; last_beat = -10; done_cyc = -1; wr = 0; a2 = -1; stall = 1'b0; held = '0;
        for (int cyc = 0; cyc < 200 && done_cyc < 0; cyc++) begin
            M_READY = toggle ? (cyc % 2 == 0) : 1'b1;
            #0;
            if (stall) chk("dump_hold", 32'({M_VALID, M_DATA}), 32'({1'b1, held}));
            if (RF_OUT1ADDRESS != RF_OUT2ADDRESS) a2 = int'(RF_OUT2ADDRESS);
            if (RF_WRITE) wr++;
            if (DONE) done_cyc = cyc;
            if (M_VALID && M_READY) begin
                if (n < 8) chk("dump_beat", 32'(M_DATA), 32'(exp_b[n]));
                n++;
                last_beat = cyc;
            end
            stall = M_VALID && !M_READY;
            held = M_DATA;
            step();
        end
        M_READY = 1'b0;
        chk("dump_beats", 32'(n), 32'(nexp));
        chk("dump_done_timing", 32'(done_cyc), 32'(last_beat + 1));
        chk("dump_no_write", 32'(wr), 32'd0);
        if (exp_a2 >= 0) chk("dump_last_addr2", 32'(a2), 32'(exp_a2));
        chk("dump_done_pulse", 32'(DONE), 32'd0);
        chk("dump_cmd_ready_back", 32'(CMD_READY), 32'd1);
        $display("dump base=%0d count=%0d toggle=%0d beats=%0d", base, cnt, toggle, n);
    endtask

    task automatic zero_cmd(input logic op);
        int done_cyc, dcount, act;
        CMD_VALID = 1'b1; CMD_OP = op; CMD_BASE = 3'd3; CMD_COUNT = 4'd0;
        step();
        CMD_VALID = 1'b0;
        done_cyc = -1; dcount = 0; act = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            if (DONE && done_cyc < 0) done_cyc = cyc;
            if (DONE) dcount++;
            if (RF_WRITE || M_VALID || S_READY) act++;
            step();
        end
        chk("zero_done_cycle", 32'(done_cyc), 32'd0);
        chk("zero_done_count", 32'(dcount), 32'd1);
        chk("zero_no_activity", 32'(act), 32'd0);
        $display("zero-count op=%0d done_cycle=%0d", op, done_cyc);
    endtask

    initial begin
        step();
        step();
        chk("rst_cmd_ready", 32'(CMD_READY), 32'd1);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_rf_write", 32'(RF_WRITE), 32'd0);
        chk("rst_s_ready", 32'(S_READY), 32'd0);
        chk("rst_m_valid", 32'(M_VALID), 32'd0);
        chk("rst_m_data", 32'(M_DATA), 32'd0);
        RESET = 1'b1;
        step();

        for (int i = 0; i < 8; i++) bytes_b[i] = 8'h10 + 8'(i);
        do_load(3'd0, 4'd8, 0);
        for (int i = 0; i < 8; i++) chk("mem_after_load", 32'(rf_mem[i]), 32'(8'h10 + 8'(i)));

        for (int i = 0; i < 8; i++) exp_b[i] = 8'h10 + 8'(i);
        do_dump(3'd0, 4'd8, 1'b0, 8, -1);
        do_dump(3'd0, 4'd8, 1'b1, 8, -1);

        bytes_b[0] = 8'hA1; bytes_b[1] = 8'hA2; bytes_b[2] = 8'hA3;
        do_load(3'd6, 4'd3, 0);
        chk("wrap_mem6", 32'(rf_mem[6]), 32'h0A1);
        chk("wrap_mem7", 32'(rf_mem[7]), 32'h0A2);
        chk("wrap_mem0", 32'(rf_mem[0]), 32'h0A3);
        chk("wrap_mem1", 32'(rf_mem[1]), 32'h011);

        exp_b[0] = 8'hA2; exp_b[1] = 8'hA3; exp_b[2] = 8'h11;
        do_dump(3'd7, 4'd3, 1'b0, 3, -1);

        exp_b[0] = 8'h12; exp_b[1] = 8'h13; exp_b[2] = 8'h14; exp_b[3] = 8'h15; exp_b[4] = 8'hA1;
        do_dump(3'd2, 4'd5, 1'b1, 5, 7);

        exp_b[0] = 8'hA3; exp_b[1] = 8'h11; exp_b[2] = 8'h12; exp_b[3] = 8'h13;
        exp_b[4] = 8'h14; exp_b[5] = 8'h15; exp_b[6] = 8'hA1; exp_b[7] = 8'hA2;
        do_dump(3'd0, 4'd15, 1'b0, 8, -1);

        zero_cmd(1'b0);
        zero_cmd(1'b1);

        for (int i = 0; i < 8; i++) bytes_b[i] = 8'hC0 + 8'(i);
        do_load(3'd0, 4'd8, 4);
        chk("abort_mem0", 32'(rf_mem[0]), 32'h0C0);
        chk("abort_mem1", 32'(rf_mem[1]), 32'h0C1);
        chk("abort_mem2", 32'(rf_mem[2]), 32'h0C2);
        chk("abort_mem3", 32'(rf_mem[3]), 32'h013);
        chk("abort_idle_ready", 32'(CMD_READY), 32'd1);

        bytes_b[0] = 8'h5A;
        do_load(3'd3, 4'd1, 0);
        chk("post_reset_mem3", 32'(rf_mem[3]), 32'h05A);
        chk("post_reset_mem4", 32'(rf_mem[4]), 32'h014);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
